// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle multiply hold,
// taken-branch flush, and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  id_rs,
   input  logic [3:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [3:0]  ex_rd,
   input  logic        ex_memread,
   input  logic        ex_mul_start,
   input  logic        branch_taken,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_stall,
   output logic        idex_bubble,
   output logic        exmem_bubble,
   output logic        mul_busy,
   output logic [15:0] stall_cycles
);

   typedef enum logic [0:0] {StRun, StMulWait} state_e;

   localparam logic [3:0] CntInit = 4'(MUL_CYCLES - 2);

   state_e     state_q;
   logic [3:0] cnt_q;
   logic       lu;
   logic       mul_hold;
   logic       mul_go;

   assign lu = ex_memread & ((id_uses_rs & (id_rs == ex_rd)) |
                             (id_uses_rt & (id_rt == ex_rd)));

   always_comb begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_stall   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      mul_hold     = (state_q == StMulWait) && (cnt_q != 4'd0);
      // A new multiply is only accepted from RUN; the release cycle ignores it.
      mul_go       = (state_q == StRun) && ex_mul_start && !branch_taken;
      if (!rst) begin
         if (mul_hold || mul_go) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
         end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StRun;
         cnt_q        <= 4'd0;
         mul_busy     <= 1'b0;
         stall_cycles <= 16'd0;
      end else begin
         if (pc_stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         unique case (state_q)
            StRun: begin
               if (mul_go) begin
                  state_q  <= StMulWait;
                  cnt_q    <= CntInit;
                  mul_busy <= 1'b1;
               end
            end
            StMulWait: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q  <= StRun;
                  mul_busy <= 1'b0;
               end
            end
            default: begin
               state_q  <= StRun;
               mul_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MUL_CYCLES=4.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rs, id_uses_rt, ex_memread, ex_mul_start, branch_taken;
   logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_bubble;
   logic        mul_busy;
   logic [15:0] stall_cycles;
   logic [5:0]  ctl;

   int npass = 0;
   int ntotal = 0;
   logic [15:0] exp_cnt;

   // ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_bubble}
   localparam logic [5:0] CtlNone = 6'b000000;
   localparam logic [5:0] CtlLu   = 6'b110010;
   localparam logic [5:0] CtlMul  = 6'b110101;
   localparam logic [5:0] CtlBr   = 6'b001010;

   assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_bubble};

   always #5 clk = ~clk;

   hazard_ctrl #(.MUL_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_mul_start(ex_mul_start), .branch_taken(branch_taken),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_stall(idex_stall), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
      .mul_busy(mul_busy), .stall_cycles(stall_cycles)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = 4'h0; id_rt = 4'h0; ex_rd = 4'h0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
      ex_mul_start = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic set_lu(input logic [3:0] r);
      ex_memread = 1'b1; ex_rd = r; id_rt = r; id_uses_rt = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         {id_rs, id_rt, ex_rd} = 12'($urandom);
         {id_uses_rs, id_uses_rt, ex_memread, ex_mul_start, branch_taken} = 5'($urandom);
         #1;
         ntotal++;
         if (ctl !== CtlNone) $display("FAIL reset_ctl got %b want %b", ctl, CtlNone);
         else npass++;
         ntotal++;
         if (mul_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", mul_busy);
         else npass++;
         ntotal++;
         if (stall_cycles !== 16'd0) $display("FAIL reset_cnt got %0d want 0", stall_cycles);
         else npass++;
      end
      clear_inputs();
      step();
      rst = 1'b0;
      exp_cnt = 16'd0;
      #1;
      ntotal++;
      if (ctl !== CtlNone) $display("FAIL idle_ctl got %b want %b", ctl, CtlNone);
      else npass++;
   endtask

   task automatic test_load_use();
      set_lu(4'h8);
      #1;
      ntotal++;
      if (ctl !== CtlLu) $display("FAIL lu_ctl got %b want %b", ctl, CtlLu);
      else npass++;
      step();
      exp_cnt = exp_cnt + 16'd1;
      id_uses_rt = 1'b0;
      #1;
      ntotal++;
      if (ctl !== CtlNone) $display("FAIL lu_unused_ctl got %b want %b", ctl, CtlNone);
      else npass++;
      ntotal++;
      if (stall_cycles !== exp_cnt) $display("FAIL lu_cnt got %0d want %0d", stall_cycles, exp_cnt);
      else npass++;
      // register 0 is a real register
      ex_rd = 4'h0; id_rs = 4'h0; id_uses_rs = 1'b1;
      #1;
      ntotal++;
      if (ctl !== CtlLu) $display("FAIL lu_r0_ctl got %b want %b", ctl, CtlLu);
      else npass++;
      step();
      exp_cnt = exp_cnt + 16'd1;
      clear_inputs();
      #1;
      ntotal++;
      if (stall_cycles !== exp_cnt) $display("FAIL lu_r0_cnt got %0d want %0d", stall_cycles, exp_cnt);
      else npass++;
   endtask

   task automatic test_mul();
      logic [5:0] want;
      logic       want_busy;
      ex_mul_start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         want      = (c < 3) ? CtlMul : CtlNone;
         want_busy = (c >= 1 && c <= 3);
         ntotal++;
         if (ctl !== want) $display("FAIL mul_ctl c%0d got %b want %b", c, ctl, want);
         else npass++;
         ntotal++;
         if (mul_busy !== want_busy) $display("FAIL mul_busy c%0d got %b want %b", c, mul_busy, want_busy);
         else npass++;
         step();
         ex_mul_start = 1'b0;
      end
      exp_cnt = exp_cnt + 16'd3;
      ntotal++;
      if (stall_cycles !== exp_cnt) $display("FAIL mul_cnt got %0d want %0d", stall_cycles, exp_cnt);
      else npass++;
   endtask

   task automatic test_branch();
      branch_taken = 1'b1;
      ex_memread = 1'b1; ex_rd = 4'hE; id_rs = 4'hE; id_uses_rs = 1'b1;
      #1;
      ntotal++;
      if (ctl !== CtlBr) $display("FAIL br_ctl got %b want %b", ctl, CtlBr);
      else npass++;
      step();
      clear_inputs();
      #1;
      ntotal++;
      if (stall_cycles !== exp_cnt) $display("FAIL br_cnt got %0d want %0d", stall_cycles, exp_cnt);
      else npass++;
   endtask

   task automatic test_release();
      logic [5:0] want [5];
      logic       want_busy [5];
      want = '{CtlMul, CtlMul, CtlMul, CtlLu, CtlNone};
      want_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 5; c++) begin
         clear_inputs();
         case (c)
            0: ex_mul_start = 1'b1;
            1: begin branch_taken = 1'b1; set_lu(4'h3); end
            2: begin ex_mul_start = 1'b1; set_lu(4'h3); end
            3: begin ex_mul_start = 1'b1; set_lu(4'hF); end
            default: ;
         endcase
         #1;
         ntotal++;
         if (ctl !== want[c]) $display("FAIL rel_ctl c%0d got %b want %b", c, ctl, want[c]);
         else npass++;
         ntotal++;
         if (mul_busy !== want_busy[c]) $display("FAIL rel_busy c%0d got %b want %b", c, mul_busy, want_busy[c]);
         else npass++;
         step();
      end
      clear_inputs();
      exp_cnt = exp_cnt + 16'd4;
      ntotal++;
      if (stall_cycles !== exp_cnt) $display("FAIL rel_cnt got %0d want %0d", stall_cycles, exp_cnt);
      else npass++;
   endtask

   task automatic test_back_to_back();
      logic [5:0] want [4];
      want = '{CtlLu, CtlNone, CtlLu, CtlNone};
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         if (c == 0) begin ex_memread = 1'b1; ex_rd = 4'h3; id_rs = 4'h3; id_uses_rs = 1'b1; end
         if (c == 2) begin ex_memread = 1'b1; ex_rd = 4'h5; id_rt = 4'h5; id_uses_rt = 1'b1; end
         #1;
         ntotal++;
         if (ctl !== want[c]) $display("FAIL b2b_ctl c%0d got %b want %b", c, ctl, want[c]);
         else npass++;
         step();
      end
      clear_inputs();
      exp_cnt = exp_cnt + 16'd2;
      ntotal++;
      if (stall_cycles !== exp_cnt) $display("FAIL b2b_cnt got %0d want %0d", stall_cycles, exp_cnt);
      else npass++;
   endtask

   task automatic test_saturation();
      set_lu(4'h8);
      for (int i = 0; i < 65540; i++) step();
      ntotal++;
      if (stall_cycles !== 16'hFFFF) $display("FAIL sat_cnt got %h want ffff", stall_cycles);
      else npass++;
      step();
      ntotal++;
      if (stall_cycles !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", stall_cycles);
      else npass++;
      clear_inputs();
   endtask

   task automatic test_reset_mid_mul();
      ex_mul_start = 1'b1;
      step();
      clear_inputs();
      #1;
      ntotal++;
      if (ctl !== CtlMul) $display("FAIL rmm_pre_ctl got %b want %b", ctl, CtlMul);
      else npass++;
      rst = 1'b1;
      #1;
      ntotal++;
      if (ctl !== CtlNone) $display("FAIL rmm_ctl got %b want %b", ctl, CtlNone);
      else npass++;
      ntotal++;
      if (mul_busy !== 1'b0) $display("FAIL rmm_busy got %b want 0", mul_busy);
      else npass++;
      ntotal++;
      if (stall_cycles !== 16'd0) $display("FAIL rmm_cnt got %0d want 0", stall_cycles);
      else npass++;
      step();
      rst = 1'b0;
      // still in MUL_WAIT this would give the multiply stall pattern
      set_lu(4'h2);
      #1;
      ntotal++;
      if (ctl !== CtlLu) $display("FAIL rmm_run_ctl got %b want %b", ctl, CtlLu);
      else npass++;
      step();
      clear_inputs();
      ntotal++;
      if (stall_cycles !== 16'd1) $display("FAIL rmm_run_cnt got %0d want 1", stall_cycles);
      else npass++;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      exp_cnt = 16'd0;
      test_reset();
      test_load_use();
      test_mul();
      test_branch();
      test_release();
      test_back_to_back();
      test_saturation();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
